// File: rtl/tone_mixer_pkg.sv
// Shared definitions for the tone mixer: register-select encodings and width helpers.
// Used by tone_mixer_pwm (optional envelope: TONE_MIXER_ENVELOPE_EN) and pwm_dac.
package tone_mixer_pkg;

   typedef enum logic {
      SEL_PERIOD = 1'b0,
      SEL_VOLUME = 1'b1
   } wr_sel_e;

   // Wide enough that summing CH full-scale amplitudes can never wrap before saturation.
   function automatic int mix_width(input int n, input int ch);
      return n + $clog2(ch) + 1;
   endfunction

   function automatic int idx_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/pwm_dac.sv
// PWM back end: free-running counter, duty latched only at the period boundary,
// registered compare output.
module pwm_dac
   import tone_mixer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] mix,
   output logic         pwm_out,
   output logic [N-1:0] duty
);

   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] duty_q, duty_d;
   logic         pwm_q, pwm_d;

   always_comb begin
      cnt_d  = cnt_q + N'(1);
      duty_d = (cnt_q == '1) ? mix : duty_q;
      pwm_d  = (cnt_q < duty_q);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
   assign duty    = duty_q;

endmodule

// File: rtl/tone_mixer_pwm.sv
// Multi-channel square-wave tone generator mixed into a single PWM output.
// Define TONE_MIXER_ENVELOPE_EN to add a per-channel linear decay envelope.
module tone_mixer_pwm
   import tone_mixer_pkg::*;
#(
   parameter int N         = 8,
   parameter int CH        = 4,
   parameter int PW        = 16,
   parameter int DECAY_DIV = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [idx_width(CH)-1:0] wr_ch,
   input  logic                     wr_sel,
   input  logic [PW-1:0]            wr_data,
   input  logic [CH-1:0]            ch_en,
   output logic                     pwm_out,
   output logic [N-1:0]             duty
);

   localparam int CW    = idx_width(CH);
   localparam int MIX_W = mix_width(N, CH);

   logic [N-1:0]     contrib [CH];
   logic             addr_ok;
   logic [MIX_W-1:0] mix_sum;
   logic [N-1:0]     mix_sat;

   assign addr_ok = (int'(wr_ch) < CH);

`ifdef TONE_MIXER_ENVELOPE_EN
   localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

   logic [DW-1:0] presc_q, presc_d;
   logic          env_tick;

   always_comb begin
      env_tick = (presc_q == DW'(DECAY_DIV - 1));
      presc_d  = env_tick ? '0 : presc_q + DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end
`endif

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [PW-1:0] period_q, period_d;
      logic [PW-1:0] cnt_q, cnt_d;
      logic          phase_q, phase_d;
      logic [N-1:0]  vol_q, vol_d;
      logic [N-1:0]  amp;
      logic          wr_hit;

      assign wr_hit = wr_en && addr_ok && (wr_ch == CW'(i));

      // NOTE: every _d gets a hold default first, so no path through the block can infer a latch.
      always_comb begin
         period_d = period_q;
         vol_d    = vol_q;
         cnt_d    = cnt_q;
         phase_d  = phase_q;
         if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (cnt_q >= period_q - PW'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + PW'(1);
         end
         // A write overrides the free-running update in the same cycle.
         if (wr_hit) begin
            if (wr_sel_e'(wr_sel) == SEL_PERIOD) begin
               period_d = wr_data;
               cnt_d    = '0;
               phase_d  = 1'b0;
            end else begin
               vol_d = wr_data[N-1:0];
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            vol_q    <= '0;
         end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            vol_q    <= vol_d;
         end
      end

`ifdef TONE_MIXER_ENVELOPE_EN
      logic [N-1:0] env_q, env_d;

      always_comb begin
         env_d = env_q;
         if (env_tick && env_q != '0) env_d = env_q - N'(1);
         if (wr_hit && wr_sel_e'(wr_sel) == SEL_VOLUME) env_d = wr_data[N-1:0];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) env_q <= '0;
         else       env_q <= env_d;
      end

      assign amp = env_q;
`else
      assign amp = vol_q;
`endif

      assign contrib[i] = (ch_en[i] && phase_q) ? amp : '0;
   end

   // NOTE: blocking assignments here build the running sum within one combinational pass.
   always_comb begin
      mix_sum = '0;
      for (int c = 0; c < CH; c++) mix_sum = mix_sum + MIX_W'(contrib[c]);
      mix_sat = (mix_sum > MIX_W'((2 ** N) - 1)) ? '1 : mix_sum[N-1:0];
   end

   pwm_dac #(.N(N)) u_pwm_dac (
      .clk     (clk),
      .reset   (reset),
      .mix     (mix_sat),
      .pwm_out (pwm_out),
      .duty    (duty)
   );

endmodule
